// File: rtl/systolic_pkg.sv
`default_nettype none
// ==========================================================================
// systolic_pkg : shared types and sizing helpers for the tile sequencer
// Revision 1.0
// ==========================================================================
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } seq_state_e;

   // Counter must reach K+2N-3 for K up to 2^KW-1 without wrapping.
   function automatic int cnt_width(input int kw, input int n);
      return kw + $clog2(n) + 1;
   endfunction

   // RUN length is K plus this skew span.
   function automatic int skew_span(input int n);
      return 2 * n - 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_seq_ctrl_if.sv
`default_nettype none
// ==========================================================================
// systolic_seq_ctrl_if : command handshake and array feed bundle
// Revision 1.0
// ==========================================================================
interface systolic_seq_ctrl_if #(
   parameter int N  = 4,
   parameter int KW = 8
);
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            mac_clear;
   logic            mac_enable;
   logic [N-1:0]    a_valid;
   logic [N*KW-1:0] a_k;
   logic [N-1:0]    b_valid;
   logic [N*KW-1:0] b_k;
   logic            result_valid;
   logic            result_ready;

   modport master (
      output start, k_len, result_ready,
      input  busy, mac_clear, mac_enable, a_valid, a_k, b_valid, b_k, result_valid
   );

   modport slave (
      input  start, k_len, result_ready,
      output busy, mac_clear, mac_enable, a_valid, a_k, b_valid, b_k, result_valid
   );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_gen.sv
`default_nettype none
// ==========================================================================
// systolic_skew_gen : per-lane skewed feed valid/index from t and K
// Revision 1.0
// ==========================================================================
module systolic_skew_gen
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  wire logic                           active,
   input  wire logic [cnt_width(KW, N)-1:0]    t,
   input  wire logic [KW-1:0]                  k_len,
   output logic      [N-1:0]                   valid,
   output logic      [N*KW-1:0]                idx
);
   localparam int c_tw = cnt_width(KW, N);

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic w_valid;

      // Lane i lags by i cycles and carries K elements.
      assign w_valid = active && (t >= c_tw'(i)) && ((t - c_tw'(i)) < c_tw'(k_len));
      assign valid[i] = w_valid;
      assign idx[i*KW +: KW] = w_valid ? KW'(t - c_tw'(i)) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// systolic_seq_ctrl : clear/run/hold sequencer for an NxN systolic tile
// Revision 1.0
// ==========================================================================
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int N  = 4,
   parameter int KW = 8
) (
   input  wire logic          clock,
   input  wire logic          reset,
   systolic_seq_ctrl_if.slave bus
);
   localparam int c_tw = cnt_width(KW, N);

   seq_state_e      r_state;
   seq_state_e      w_next;
   logic [c_tw-1:0] r_t;
   logic [KW-1:0]   r_k;
   logic [c_tw-1:0] w_run_last;
   logic            w_last;
   logic            w_run;

   // Only evaluated in RUN, where K >= 1, so the subtraction cannot underflow.
   assign w_run_last = c_tw'(r_k) + c_tw'(skew_span(N)) - c_tw'(1);
   assign w_last     = (r_t == w_run_last);
   assign w_run      = (r_state == RUN);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start)        w_next = CLEAR;
         CLEAR:   w_next = (r_k == '0) ? HOLD : RUN;
         RUN:     if (w_last)           w_next = HOLD;
         HOLD:    if (bus.result_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_t <= '0;
         r_k <= '0;
      end else begin
         if (r_state == IDLE && bus.start) begin
            r_k <= bus.k_len;
         end
         if (w_run && !w_last) begin
            r_t <= r_t + c_tw'(1);
         end else begin
            r_t <= '0;
         end
      end
   end

   always_comb begin
      bus.busy         = 1'b0;
      bus.mac_clear    = 1'b0;
      bus.mac_enable   = 1'b0;
      bus.result_valid = 1'b0;
      case (r_state)
         IDLE:  ;
         CLEAR: begin
            bus.busy      = 1'b1;
            bus.mac_clear = 1'b1;
         end
         RUN: begin
            bus.busy       = 1'b1;
            bus.mac_enable = 1'b1;
         end
         HOLD: begin
            bus.busy         = 1'b1;
            bus.result_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Row and column skews are identical, so one generator serves each edge.
   systolic_skew_gen #(.N(N), .KW(KW)) u_row_skew (
      .active (w_run),
      .t      (r_t),
      .k_len  (r_k),
      .valid  (bus.a_valid),
      .idx    (bus.a_k)
   );

   systolic_skew_gen #(.N(N), .KW(KW)) u_col_skew (
      .active (w_run),
      .t      (r_t),
      .k_len  (r_k),
      .valid  (bus.b_valid),
      .idx    (bus.b_k)
   );

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_systolic_seq_ctrl : directed bench with a 4x4 output-stationary PE model
// Revision 1.0
// ==========================================================================
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   systolic_seq_ctrl_if #(.N(4), .KW(8)) bus ();

   systolic_seq_ctrl #(.N(4), .KW(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // PE array model: A = identity, B[k][j] = 4k + j.
   function automatic logic [31:0] a_val(input int i, input int k);
      return (i == k) ? 32'd1 : 32'd0;
   endfunction
   function automatic logic [31:0] b_val(input int k, input int j);
      return 32'(k * 4 + j);
   endfunction

   logic [31:0] m_ain  [4][4];
   logic [31:0] m_bin  [4][4];
   logic [31:0] m_areg [4][4];
   logic [31:0] m_breg [4][4];
   logic [31:0] m_acc  [4][4];
   logic [31:0] acc_snap [4][4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         m_ain[i][0] = bus.a_valid[i] ? a_val(i, int'(bus.a_k[i*8 +: 8])) : 32'd0;
         m_bin[0][i] = bus.b_valid[i] ? b_val(int'(bus.b_k[i*8 +: 8]), i) : 32'd0;
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 1; j < 4; j++) begin
            m_ain[i][j] = m_areg[i][j-1];
            m_bin[j][i] = m_breg[j-1][i];
         end
      end
   end

   always @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (reset) begin
               m_areg[i][j] <= '0;
               m_breg[i][j] <= '0;
               m_acc[i][j]  <= '0;
            end else begin
               m_areg[i][j] <= m_ain[i][j];
               m_breg[i][j] <= m_bin[i][j];
               if (bus.mac_clear)       m_acc[i][j] <= '0;
               else if (bus.mac_enable) m_acc[i][j] <= m_acc[i][j] + m_ain[i][j] * m_bin[i][j];
            end
         end
      end
   end

   // Per-tile observation log; cyc 0 is the cycle start is sampled in IDLE.
   int   cyc;
   int   clr_first, clr_cnt, en_first, en_last, en_cnt, rv_first, rv_rise;
   logic rv_prev;
   logic [3:0]  av_log [64];
   logic [3:0]  bv_log [64];
   logic [31:0] ak_log [64];
   logic [31:0] bk_log [64];

   task automatic log_cycle();
      if (bus.mac_clear) begin
         if (clr_cnt == 0) clr_first = cyc;
         clr_cnt++;
      end
      if (bus.mac_enable) begin
         if (en_cnt == 0) en_first = cyc;
         en_last = cyc;
         en_cnt++;
      end
      if (bus.result_valid && !rv_prev) begin
         rv_rise++;
         if (rv_first < 0) rv_first = cyc;
      end
      rv_prev = bus.result_valid;
      if (cyc < 64) begin
         av_log[cyc] = bus.a_valid;
         bv_log[cyc] = bus.b_valid;
         ak_log[cyc] = bus.a_k;
         bk_log[cyc] = bus.b_k;
      end
   endtask

   task automatic start_tile(input logic [7:0] k);
      cyc = 0;
      clr_first = -1; clr_cnt = 0; en_first = -1; en_last = -1; en_cnt = 0;
      rv_first = -1; rv_rise = 0; rv_prev = 1'b0;
      bus.start = 1'b1;
      bus.k_len = k;
      log_cycle();
   endtask

   task automatic step_to(input int last, input int s1 = -1, input int s2 = -1);
      while (cyc < last) begin
         @(posedge clock);
         #1;
         cyc++;
         bus.start = (cyc == s1) || (cyc == s2);
         log_cycle();
      end
   endtask

   initial begin
      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.k_len        = '0;
      bus.result_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy",    64'(bus.busy),         64'd0);
      check("rst_clear",   64'(bus.mac_clear),    64'd0);
      check("rst_enable",  64'(bus.mac_enable),   64'd0);
      check("rst_rvalid",  64'(bus.result_valid), 64'd0);
      check("rst_avalid",  64'(bus.a_valid),      64'd0);
      check("rst_bvalid",  64'(bus.b_valid),      64'd0);
      check("rst_ak",      64'(bus.a_k),          64'd0);
      check("rst_bk",      64'(bus.b_k),          64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Nominal K=8 tile with 5 cycles of backpressure
      start_tile(8'd8);
      check("nom_busy_c0", 64'(bus.busy), 64'd0);
      step_to(16);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            acc_snap[i][j] = m_acc[i][j];
      step_to(21);
      check("nom_clr_first", 64'(clr_first), 64'd1);
      check("nom_clr_cnt",   64'(clr_cnt),   64'd1);
      check("nom_en_first",  64'(en_first),  64'd2);
      check("nom_en_last",   64'(en_last),   64'd15);
      check("nom_en_cnt",    64'(en_cnt),    64'd14);
      check("nom_rv_first",  64'(rv_first),  64'd16);
      check("nom_av_c2",     64'(av_log[2]),  64'h1);
      check("nom_ak_c2",     64'(ak_log[2]),  64'h0);
      check("nom_av_t3",     64'(av_log[5]),  64'hf);
      check("nom_ak_t3",     64'(ak_log[5]),  64'h00010203);
      check("nom_av_t8",     64'(av_log[10]), 64'he);
      check("nom_ak_t8",     64'(ak_log[10]), 64'h05060700);
      check("nom_av_t10",    64'(av_log[12]), 64'h8);
      check("nom_ak_t10",    64'(ak_log[12]), 64'h07000000);
      check("nom_bv_t10",    64'(bv_log[12]), 64'h8);
      check("nom_bk_t10",    64'(bk_log[12]), 64'h07000000);
      check("nom_av_t13",    64'(av_log[15]), 64'h0);
      check("nom_av_hold",   64'(av_log[16]), 64'h0);
      check("bp_rvalid",     64'(bus.result_valid), 64'd1);
      check("bp_rv_rise",    64'(rv_rise),   64'd1);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            check($sformatf("c_%0d_%0d", i, j), 64'(m_acc[i][j]), 64'(i * 4 + j));
            check($sformatf("bp_acc_%0d_%0d", i, j), 64'(m_acc[i][j]), 64'(acc_snap[i][j]));
         end
      end
      bus.result_ready = 1'b1;
      step_to(22);
      bus.result_ready = 1'b0;
      check("nom_exit_busy",   64'(bus.busy),         64'd0);
      check("nom_exit_rvalid", 64'(bus.result_valid), 64'd0);

      // K=0: clear then straight to hold
      start_tile(8'd0);
      step_to(4);
      check("k0_clr_first", 64'(clr_first), 64'd1);
      check("k0_en_cnt",    64'(en_cnt),    64'd0);
      check("k0_rv_first",  64'(rv_first),  64'd2);
      bus.result_ready = 1'b1;
      step_to(5);
      bus.result_ready = 1'b0;
      check("k0_exit_busy", 64'(bus.busy), 64'd0);

      // Ignored starts in RUN, HOLD and the HOLD exit cycle
      start_tile(8'd2);
      step_to(12, 3, 11);
      bus.result_ready = 1'b1;
      bus.start        = 1'b1;
      step_to(13);
      bus.result_ready = 1'b0;
      check("ign_exit_busy", 64'(bus.busy), 64'd0);
      step_to(17);
      check("ign_idle_busy", 64'(bus.busy), 64'd0);
      check("ign_rv_rise",   64'(rv_rise),  64'd1);
      check("ign_rv_first",  64'(rv_first), 64'd10);
      check("ign_en_cnt",    64'(en_cnt),   64'd8);
      check("ign_clr_cnt",   64'(clr_cnt),  64'd1);

      // Mid-run reset at t=5, then a fresh K=3 tile
      start_tile(8'd8);
      step_to(7);
      check("mr_enable_t5", 64'(bus.mac_enable), 64'd1);
      reset = 1'b1;
      step_to(8);
      check("mr_busy",   64'(bus.busy),       64'd0);
      check("mr_enable", 64'(bus.mac_enable), 64'd0);
      check("mr_avalid", 64'(bus.a_valid),    64'd0);
      check("mr_ak",     64'(bus.a_k),        64'd0);
      reset = 1'b0;
      start_tile(8'd3);
      step_to(12);
      check("mr_clr_first", 64'(clr_first), 64'd1);
      check("mr_en_cnt",    64'(en_cnt),    64'd9);
      check("mr_en_last",   64'(en_last),   64'd10);
      check("mr_rv_first",  64'(rv_first),  64'd11);
      for (int i = 0; i < 3; i++)
         check($sformatf("mr_c_%0d_0", i), 64'(m_acc[i][0]), 64'(i * 4));
      bus.result_ready = 1'b1;
      step_to(13);
      bus.result_ready = 1'b0;
      check("mr_exit_busy", 64'(bus.busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for one N×N output-stationary systolic tile built from `mac_unit` processing elements. It computes C = A·B with A of size N×K and B of size K×N. The block accepts a start request and a K length, clears all accumulators, and drives the global `enable`. It also generates the skewed per-row and per-column operand-feed indices for the edge operand buffers, then holds the accumulator results until they are acknowledged. It sits between the tile command interface and the array, alongside the row (A) and column (B) operand buffers.

## Interface
- `N`, default 4: array dimension (rows = columns); valid range 2..16.
- `KW`, default 8: width of the K length and of the feed-index outputs.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a tile; sampled only in IDLE.
- `k_len`  in  KW: reduction length K; latched on an accepted start.
- `busy`  out  1: high in every state except IDLE.
- `mac_clear`  out  1: drives `clear_acc` of all PEs.
- `mac_enable`  out  1: drives `enable` of all PEs.
- `a_valid`  out  N: per-row feed valid. The row buffer drives A[i][a_k[i]] when set, otherwise 0.
- `a_k`  out  N*KW: per-row feed index; row i is in bits [i*KW +: KW].
- `b_valid`  out  N: per-column feed valid. The column buffer drives B[b_k[j]][j] when set, otherwise 0.
- `b_k`  out  N*KW: per-column feed index, packed the same way as `a_k`.
- `result_valid`  out  1: accumulators are final and stable.
- `result_ready`  in  1: consumer has read the results.

## Operation
- States are IDLE, CLEAR, RUN and HOLD.
- **IDLE**
  - On `start`=1: latch K, go to CLEAR.
  - Otherwise stay in IDLE.
- **CLEAR**
  - Asserts `mac_clear`=1 for exactly 1 cycle.
  - If K=0, go to HOLD (results are all zero).
  - Otherwise go to RUN with the cycle counter t=0.
- **RUN**
  - Lasts T = K+2N−2 cycles, t = 0..T−1, with `mac_enable`=1 throughout.
  - Row i: `a_valid[i]` = (t ≥ i) && (t−i < K), and `a_k[i]` = t−i.
  - Column j: `b_valid[j]` = (t ≥ j) && (t−j < K), and `b_k[j]` = t−j.
  - When a valid bit is 0, its index output is 0.
  - PE(i,j) accumulates A[i][k]·B[k][j] at RUN cycle i+j+k. This relies on the PE's 1-cycle operand pass-through.
  - Zero feed during the skew cycles contributes 0 to the accumulators.
  - At t=T−1, go to HOLD.
- **HOLD**
  - `result_valid`=1 and `mac_enable`=0, so the accumulators stay frozen.
  - When `result_ready`=1, return to IDLE on that edge.
  - `result_valid` is held while `result_ready`=0.
- `start` outside IDLE is ignored and is not queued.
- `start` in the same cycle as a HOLD→IDLE exit is ignored. A new tile needs `start` with the block in IDLE.
- Counter t is `KW+$clog2(N)+1` bits wide and never wraps. K=2^KW−1 is legal.
- Saturation is handled inside the PEs. The controller does not observe accumulator values.

## Timing
- Reset values:
  - State is IDLE; t=0.
  - `busy`, `mac_clear`, `mac_enable` and `result_valid` are 0.
  - `a_valid` and `b_valid` are all 0; `a_k` and `b_k` are all 0.
- Cycle numbering: the cycle in which `start` is sampled in IDLE is cycle 0.
  - Cycle 1: CLEAR.
  - Cycles 2..K+2N−1: RUN.
  - `result_valid` first rises in cycle K+2N. For K=0 it rises in cycle 2.
- All outputs are Moore functions of the registered state and t. There is no combinational path from inputs to outputs.
- `reset` asserted mid-operation returns the block to IDLE on the next edge with reset values applied. The next accepted start re-clears the PEs, so no partial results leak.

## Structure
- Shared package `systolic_pkg` holds:
  - the `seq_state_e` enum (IDLE, CLEAR, RUN, HOLD);
  - localparam helpers for the run length (K+2N−2) and the counter width.
- Sub-module `systolic_skew_gen` (params N, KW): given t and K, it produces N valid bits and N packed indices.
  - Instantiated twice, once for rows and once for columns.
  - The two instances are identical, because the skew of row i equals the skew of column j when i=j.
- Top level holds the FSM, the t counter and the K register.

## Test plan
- **Reset:** reset for 3 cycles → every output 0, `busy`=0.
- **Nominal tile:** N=4, K=8, start at cycle 0:
  - `mac_clear` is high only in cycle 1.
  - `mac_enable` is high in cycles 2..15.
  - In cycle 2: `a_valid`=4'b0001, `a_k[0]`=0.
  - At t=10: `a_valid`=4'b1000, `a_k[3]`=7.
  - `result_valid` rises in cycle 16.
  - With a PE array model and A=I, B=[k·4+j], C equals B.
- **K=0:** start → CLEAR at cycle 1, `result_valid` at cycle 2, no `mac_enable` pulse.
- **Backpressure:** `result_ready` held low for 5 cycles → `result_valid` stays high and the accumulators do not change. Ready high for 1 cycle → IDLE on the next edge.
- **Ignored start:** start pulses during RUN and HOLD, and in the HOLD exit cycle → no effect, and exactly one tile completes.
- **Mid-run reset:** reset at t=5 → IDLE on the next edge. A new start with K=3 completes with `result_valid` at cycle 3+8=11.
